if_id_instr_buffer: RTL and testbench
=====================================

// Module: if_id_instr_buffer
// PURPOSE
//  Decoupling queue between instruction fetch and the ID-stage decoder.
//  - Captures {pc, instr} pairs from fetch with a valid/ready handshake.
//  - Presents the oldest pair to decode, with a registered valid.
//  - Drops all contents on a pipeline flush (branch mispredict or trap).
//  - Empty slots present a canonical NOP, so decode sees ADDI x0,x0,0 whenever invalid.
// PARAMETERS
//  XLEN   32  width of PC and instruction words
//  DEPTH  2   entry count; power of two, >=2
//  NOP    32'h0000_0013  instruction word driven on o_id_instr while empty
// PORTS
//  i_clk           in   1     clock; all state updates on rising edge
//  i_rst           in   1     asynchronous, active-high reset
//  i_flush         in   1     discard all entries this cycle
//  i_fetch_valid   in   1     fetch offers a pair
//  o_fetch_ready   out  1     buffer can accept a pair this cycle
//  i_fetch_pc      in   XLEN  PC of the offered instruction
//  i_fetch_instr   in   XLEN  offered instruction word
//  o_id_valid      out  1     head entry valid for decode
//  i_id_ready      in   1     decode consumes head this cycle
//  o_id_pc         out  XLEN  head PC; 0 when empty
//  o_id_instr      out  XLEN  head instruction; NOP when empty
//  o_count         out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the surrounding reset tree):
//    - count=0, rd_ptr=wr_ptr=0, o_id_valid=0, o_id_pc=0.
//    - o_id_instr=NOP, o_fetch_ready=1.
//  - Push: push = i_fetch_valid & o_fetch_ready & ~i_flush.
//    - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
//  - Pop: pop = o_id_valid & i_id_ready & ~i_flush.
//    - rd_ptr increments modulo DEPTH.
//  - Ready: o_fetch_ready = (count != DEPTH). It depends on registered count only, with no
//    combinational path from i_id_ready, so a full buffer refuses a push even while popping.
//  - Valid: o_id_valid = (count != 0). Outputs are driven from mem[rd_ptr].
//    - Latency is 1 cycle: a pair pushed at edge N appears at o_id_* after edge N
//      if the buffer was empty.
//    - No input-to-output combinational path exists except the muxing of
//      o_id_pc/o_id_instr from mem[rd_ptr].
//  - Count: next_count = count + push - pop. Push and pop in the same cycle leave count
//    unchanged; this is legal at any count between 1 and DEPTH-1.
//  - Order: strict FIFO. Pointers wrap at DEPTH-1 -> 0 with no bubble.
//  - Flush: i_flush=1 at edge N sets count=0 and rd_ptr=wr_ptr=0 after edge N.
//    - The push and pop of that cycle are both suppressed.
//    - Memory contents are not cleared; outputs read NOP/0 because count=0.
//  - Stall hold: when o_id_valid=1 and i_id_ready=0, o_id_pc and o_id_instr stay stable
//    until popped or flushed.
//  - Reset mid-operation: all entries are lost immediately (asynchronous), and outputs
//    go to their reset values in the same cycle.
//  - No X propagation: when empty, o_id_pc and o_id_instr are forced to 0 and NOP
//    regardless of memory contents.
// TESTING
//  1. Reset -> o_id_valid=0, o_id_instr=32'h13, o_fetch_ready=1, o_count=0.
//  2. Push {0x100,0x00500093} with i_id_ready=0 -> next cycle o_id_valid=1,
//     o_id_pc=0x100; the values are held for 5 stall cycles.
//  3. Fill to DEPTH=2 with i_id_ready=0 -> o_fetch_ready=0.
//     Then i_fetch_valid=1 and i_id_ready=1 -> one pop, no push, o_count=1.
//  4. Stream 8 pairs (PC 0x0..0x1C) with both sides always ready -> decode receives
//     them in order, one per cycle after the first, across pointer wrap.
//  5. Buffer holding 2 entries, assert i_flush together with i_fetch_valid=1 ->
//     o_count=0 and o_id_instr=NOP next cycle; the offered pair is not stored.
//  6. Assert i_rst asynchronously mid-stream (between clock edges) -> o_id_valid
//     drops before the next edge; after release the first push reappears with 1-cycle latency.

Source files
------------

// File: rtl/if_id_instr_buffer.sv
// Decoupling FIFO between instruction fetch and the ID-stage decoder.
// Holds {pc, instr} pairs. It presents the oldest pair with a registered valid.
// When the buffer is empty, decode sees a canonical NOP at PC 0.
module if_id_instr_buffer #(
    parameter int unsigned     XLEN  = 32,
    parameter int unsigned     DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_fetch_valid,
    output logic                     o_fetch_ready,
    input  logic [XLEN-1:0]          i_fetch_pc,
    input  logic [XLEN-1:0]          i_fetch_instr,
    output logic                     o_id_valid,
    input  logic                     i_id_ready,
    output logic [XLEN-1:0]          o_id_pc,
    output logic [XLEN-1:0]          o_id_instr,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [XLEN-1:0]  mem_instr [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready and valid come only from registered count, so there is no ready-to-ready path
    assign o_fetch_ready = (count_q != CNT_W'(DEPTH));
    assign o_id_valid    = (count_q != '0);
    assign o_count       = count_q;

    // Head pair, forced to 0/NOP when empty so stale or unwritten memory never leaks out
    always_comb begin
        o_id_pc    = '0;
        o_id_instr = NOP;
        if (o_id_valid) begin
            o_id_pc    = mem_pc[rd_ptr_q];
            o_id_instr = mem_instr[rd_ptr_q];
        end
    end

    // Handshake qualification and next pointer/count values; flush wins over everything
    always_comb begin
        push     = i_fetch_valid & o_fetch_ready & ~i_flush;
        pop      = o_id_valid & i_id_ready & ~i_flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, which has no reset because the empty-state muxing hides its contents
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= i_fetch_pc;
            mem_instr[wr_ptr_q] <= i_fetch_instr;
        end
    end

endmodule

// File: tb/tb_if_id_instr_buffer.sv
// Self-checking bench for if_id_instr_buffer: directed vector table, hand sequences
// for streaming and asynchronous reset, and random traffic against a queue model.
module tb_if_id_instr_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush, fetch_valid, fetch_ready, id_valid, id_ready;
    logic [XLEN-1:0] fetch_pc, fetch_instr, id_pc, id_instr;
    logic [1:0]      count;

    int checks = 0;
    int errors = 0;

    if_id_instr_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_fetch_valid (fetch_valid),
        .o_fetch_ready (fetch_ready),
        .i_fetch_pc    (fetch_pc),
        .i_fetch_instr (fetch_instr),
        .o_id_valid    (id_valid),
        .i_id_ready    (id_ready),
        .o_id_pc       (id_pc),
        .o_id_instr    (id_instr),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_ready;
        int          e_count;
    } vec_t;

    vec_t vecs [13];

    // Reference model: a plain queue of {pc, instr} with the handshake rules
    logic [63:0] model_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic fv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy);
        flush       = f;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = ins;
        id_ready    = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic model_update(input logic f, input logic fv, input logic [31:0] pc,
                                input logic [31:0] ins, input logic rdy);
        bit do_push, do_pop;
        do_push = fv && (model_q.size() != DEPTH) && !f;
        do_pop  = (model_q.size() != 0) && rdy && !f;
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        bit          nonempty;
        nonempty = (model_q.size() != 0);
        head     = nonempty ? model_q[0] : {32'h0, NOP};
        check({tag, ".valid"}, 64'(id_valid), 64'(nonempty));
        check({tag, ".pc"},    64'(id_pc),    64'(head[63:32]));
        check({tag, ".instr"}, 64'(id_instr), 64'(head[31:0]));
        check({tag, ".ready"}, 64'(fetch_ready), 64'(model_q.size() != DEPTH));
        check({tag, ".count"}, 64'(count),    64'(model_q.size()));
    endtask

    initial begin
        // Directed table: push with stall, fill, pop-while-full, flush with offer, refill
        vecs[0]  = '{1'b0, 1'b1, 32'h100, 32'h00500093, 1'b0, 1'b1, 32'h100, 32'h00500093, 1'b1, 1};
        for (int i = 1; i <= 5; i++)
            vecs[i] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h00500093, 1'b1, 1};
        vecs[6]  = '{1'b0, 1'b1, 32'h104, 32'h00A00113, 1'b0, 1'b1, 32'h100, 32'h00500093, 1'b0, 2};
        vecs[7]  = '{1'b0, 1'b1, 32'h108, 32'h00000AAA, 1'b1, 1'b1, 32'h104, 32'h00A00113, 1'b1, 1};
        vecs[8]  = '{1'b0, 1'b1, 32'h10C, 32'h00000BBB, 1'b0, 1'b1, 32'h104, 32'h00A00113, 1'b0, 2};
        vecs[9]  = '{1'b1, 1'b1, 32'h110, 32'h00000CCC, 1'b1, 1'b0, 32'h0,   NOP,          1'b1, 0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   NOP,          1'b1, 0};
        vecs[11] = '{1'b0, 1'b1, 32'h200, 32'h00000222, 1'b1, 1'b1, 32'h200, 32'h00000222, 1'b1, 1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   NOP,          1'b1, 0};

        // Reset state, sampled while reset is still asserted
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst.valid", 64'(id_valid), 64'(0));
        check("rst.instr", 64'(id_instr), 64'(NOP));
        check("rst.pc",    64'(id_pc),    64'(0));
        check("rst.ready", 64'(fetch_ready), 64'(1));
        check("rst.count", 64'(count),    64'(0));
        step();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].rdy);
            step();
            check($sformatf("vec%0d.valid", i), 64'(id_valid),    64'(vecs[i].e_valid));
            check($sformatf("vec%0d.pc", i),    64'(id_pc),       64'(vecs[i].e_pc));
            check($sformatf("vec%0d.instr", i), 64'(id_instr),    64'(vecs[i].e_instr));
            check($sformatf("vec%0d.ready", i), 64'(fetch_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d.count", i), 64'(count),       64'(vecs[i].e_count));
        end

        // Stream 8 pairs with both sides always ready; head after edge k is pair k
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b1);
            step();
            check($sformatf("stream%0d.pc", i),    64'(id_pc),    64'(i * 4));
            check($sformatf("stream%0d.instr", i), 64'(id_instr), 64'(32'hA000_0000 | 32'(i)));
            check($sformatf("stream%0d.count", i), 64'(count),    64'(1));
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        check("stream.drain.valid", 64'(id_valid), 64'(0));

        // Asynchronous reset between clock edges
        do_reset();
        drive(1'b0, 1'b1, 32'h300, 32'h00000333, 1'b0);
        step();
        check("arst.pre.valid", 64'(id_valid), 64'(1));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 64'(id_valid), 64'(0));
        check("arst.count", 64'(count),    64'(0));
        check("arst.instr", 64'(id_instr), 64'(NOP));
        check("arst.pc",    64'(id_pc),    64'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h304, 32'h00000444, 1'b0);
        step();
        check("arst.post.valid", 64'(id_valid), 64'(1));
        check("arst.post.pc",    64'(id_pc),    64'(32'h304));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check("arst.hold.pc", 64'(id_pc), 64'(32'h304));

        // Random traffic against the queue model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic        f, fv, rdy;
            logic [31:0] pc, ins;
            f   = ($urandom_range(15) == 0);
            fv  = ($urandom_range(3) != 0);
            rdy = ($urandom_range(2) != 0);
            pc  = $urandom;
            ins = $urandom;
            drive(f, fv, pc, ins, rdy);
            check($sformatf("rnd%0d.pre_ready", n), 64'(fetch_ready),
                  64'(model_q.size() != DEPTH));
            model_update(f, fv, pc, ins, rdy);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
